// File: rtl/bcd_seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seg7_scan
//  Description : Time-multiplexed 3-digit 7-segment driver with frame-latched
//                digits, anti-ghost blank gap and leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_seg7_scan #(
    parameter int CLK_DIV     = 50000,
    parameter int BLANK_CYC   = 16,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dec_in0,
    input  logic [3:0] dec_in1,
    input  logic [3:0] dec_in2,
    input  logic       blank_en,
    input  logic [2:0] dp_mask,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] dig_sel
);

    localparam int              C_DW         = $clog2(CLK_DIV);
    localparam int              C_BW         = (BLANK_CYC < 1) ? 1 : $clog2(BLANK_CYC + 1);
    localparam logic [C_DW-1:0] C_DIV_MAX    = C_DW'(CLK_DIV - 1);
    localparam logic [C_BW-1:0] C_BLANK_LOAD = C_BW'(BLANK_CYC);
    localparam logic [6:0]      C_SEG_INV    = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic            C_DP_INV     = (SEG_ACT_LOW != 0);
    localparam logic [2:0]      C_DIG_INV    = (DIG_ACT_LOW != 0) ? 3'b111 : 3'b000;

    logic [C_DW-1:0] r_div_cnt;
    logic [1:0]      r_scan_idx;
    logic [C_BW-1:0] r_blank_cnt;
    logic [3:0]      r_sh0;
    logic [3:0]      r_sh1;
    logic [3:0]      r_sh2;
    logic [2:0]      r_sh_dp;

    logic            w_tick;
    logic [3:0]      w_digit;
    logic            w_dp_ah;
    logic [2:0]      w_dig_ah;
    logic            w_lz_blank;
    logic [6:0]      w_seg_ah;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        w_tick     = (r_div_cnt == C_DIV_MAX);
        w_digit    = 4'd0;
        w_dp_ah    = 1'b0;
        w_dig_ah   = 3'b000;
        w_lz_blank = 1'b0;
        case (r_scan_idx)
            2'd0: begin
                w_digit  = r_sh0;
                w_dp_ah  = r_sh_dp[0];
                w_dig_ah = 3'b001;
            end
            2'd1: begin
                w_digit    = r_sh1;
                w_dp_ah    = r_sh_dp[1];
                w_dig_ah   = 3'b010;
                w_lz_blank = blank_en && (r_sh2 == 4'd0) && (r_sh1 == 4'd0);
            end
            2'd2: begin
                w_digit    = r_sh2;
                w_dp_ah    = r_sh_dp[2];
                w_dig_ah   = 3'b100;
                w_lz_blank = blank_en && (r_sh2 == 4'd0);
            end
            default: ;
        endcase
        w_seg_ah = w_lz_blank ? 7'h00 : seg_decode(w_digit);
    end

    // Shadow digits only move at the frame wrap so a frame never mixes two values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt   <= '0;
            r_scan_idx  <= 2'd0;
            r_blank_cnt <= '0;
            r_sh0       <= 4'd0;
            r_sh1       <= 4'd0;
            r_sh2       <= 4'd0;
            r_sh_dp     <= 3'b000;
            seg         <= C_SEG_INV;
            dp          <= C_DP_INV;
            dig_sel     <= C_DIG_INV;
        end else begin
            if (w_tick) begin
                r_div_cnt   <= '0;
                r_scan_idx  <= (r_scan_idx == 2'd2) ? 2'd0 : r_scan_idx + 2'd1;
                r_blank_cnt <= C_BLANK_LOAD;
                if (r_scan_idx == 2'd2) begin
                    r_sh0   <= dec_in0;
                    r_sh1   <= dec_in1;
                    r_sh2   <= dec_in2;
                    r_sh_dp <= dp_mask;
                end
            end else begin
                r_div_cnt <= r_div_cnt + C_DW'(1);
                if (r_blank_cnt != '0) begin
                    r_blank_cnt <= r_blank_cnt - C_BW'(1);
                end
            end

            if (r_blank_cnt != '0) begin
                seg     <= C_SEG_INV;
                dp      <= C_DP_INV;
                dig_sel <= C_DIG_INV;
            end else begin
                seg     <= w_seg_ah ^ C_SEG_INV;
                dp      <= w_dp_ah ^ C_DP_INV;
                dig_sel <= w_dig_ah ^ C_DIG_INV;
            end
        end
    end

endmodule
`default_nettype wire
